tt_um_ethansam9_count_checker: RTL and testbench
================================================

# tt_um_ethansam9_count_checker

Receive-side companion to the `tt_um_ethansam9_counter` tile. It samples an 8-bit count stream on `ui_in` and checks that each sample is the previous one plus 1, modulo 256. It locks onto the stream, counts sequence errors, and detects loss of lock. It uses the Tiny Tapeout tile pinout, so it can be wired directly to the counter's `uo_out`, either on a board or in a shared testbench.

## Interface
Parameters:
- `LOCK_N`, 4: consecutive matching samples in ACQ needed to enter LOCKED (1..15).
- `LOSS_N`, 2: consecutive mismatching samples in LOCKED needed to drop back to ACQ (1..15).

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ena`  in  1  tile enable; when low, no sample is taken (same effect as `valid`=0).
- `ui_in`  in  8  observed count value.
- `uio_in`  in  8  bit 0 = `valid` (sample this cycle); bit 1 = `clear` (error counter and sticky flag); bits 7:2 unused.
- `uo_out`  out  8  status word:
  - [3:0] `err_cnt`
  - [4] `err_sticky`
  - [5] `locked`
  - [7:6] state
- `uio_out`  out  8  [7:4] `samp_cnt` (valid samples taken, mod 16); [3:0] tied to 0.
- `uio_oe`  out  8  constant 8'hF0, including during reset.

## Operation
- A sample is taken on a rising edge when `ena`=1 and `valid`=1. `valid` is level-sensitive, so holding it high samples every cycle.
- Internal registers:
  - `exp`, 8 bits: the expected next value.
  - `good_run` and `miss_run`, 4 bits each: consecutive match and mismatch counts.
- States and their encoding on `uo_out[7:6]`: IDLE=00, ACQ=01, LOCKED=10. Encoding 11 is unused and recovers to IDLE.
- On every sample, `exp` <= sample + 1, mod 256. The checker always resyncs to the observed value, so 255 followed by 0 is a match.
- IDLE:
  - First sample -> ACQ, with `good_run`=0.
  - No error accounting.
- ACQ:
  - Match: `good_run`++. If the incremented `good_run` equals `LOCK_N`, go to LOCKED with `miss_run`=0.
  - Mismatch: `good_run`=0 and stay in ACQ. Mismatches in ACQ are not counted as errors.
- LOCKED:
  - Match: `miss_run`=0.
  - Mismatch: `err_cnt`++ (saturates at 15), `err_sticky`=1, `miss_run`++.
  - If the incremented `miss_run` equals `LOSS_N`, go to ACQ with `good_run`=0.
- `locked` = (state == LOCKED).
- `clear` takes effect on the edge whether or not a sample is taken: `err_cnt`=0 and `err_sticky`=0.
- `clear` together with a LOCKED mismatch in the same cycle: clear is applied first, then the error is counted, giving `err_cnt`=1 and `err_sticky`=1.
- `clear` never changes the state, `exp`, or the run counters.
- `samp_cnt` increments on every sample and wraps 15 -> 0.

## Timing
- All outputs are registered. Effects of a sample taken on edge N are visible on the outputs right after edge N.
- Reset values, applied asynchronously on `rst` assertion:
  - state = IDLE.
  - `exp`, `good_run`, `miss_run`, `err_cnt`, `err_sticky`, `samp_cnt` = 0.
  - Result: `uo_out`=0x00, `uio_out`=0x00, `uio_oe`=0xF0.
- Reset asserted mid-operation (any state) returns everything to these values. After release, the first sample is always treated as an IDLE acquisition.
- Minimum time to lock from reset: 1 + `LOCK_N` samples.
- Minimum time to lose lock: `LOSS_N` consecutive mismatching samples.

## Structure
- Package `count_checker_pkg` holds:
  - the state enum (IDLE/ACQ/LOCKED, 2 bits);
  - `CNT_W`=8 and `RUN_W`=4;
  - `uo_out` bit-position constants;
  - `UIO_OE_VAL`=8'hF0.
- Sub-module `count_checker_core`:
  - Contains the FSM and all counters, with plain ports: `clk`, `rst`, `sample_en`, `sample[7:0]`, `clear`, `err_cnt`, `err_sticky`, `state`, `samp_cnt`.
  - The tile top only does pin mapping and gating: `sample_en` = `ena` & `uio_in[0]`.

## Test plan
1. **Acquire and lock.** Reset, then `valid`=1 and feed 0,1,2,3,4 -> IDLE->ACQ after 0; LOCKED after 4; `uo_out`=0xA0; `samp_cnt`=5.
2. **Wrap-around.** Locked, feed 253,254,255,0,1 -> `err_cnt` stays 0 and the block stays LOCKED.
3. **Single glitch.** Locked with last sample 10, feed 11,13,14 -> after 13: `err_cnt`=1, `err_sticky`=1, still LOCKED. After 14: `miss_run`=0, `uo_out`=0xB1.
4. **Loss of lock.** Locked, feed two consecutive mismatches (e.g. 50 after 20, then 70) -> `err_cnt`=2, state ACQ, `uo_out`=0x52. Then 71,72,73,74 -> LOCKED again.
5. **Saturation and clear.**
   - Alternate lock and loss until 20 errors have occurred -> `err_cnt` holds 15.
   - `clear` alone -> `err_cnt`=0 and `err_sticky`=0.
   - `clear` coincident with a LOCKED mismatch -> `err_cnt`=1 and `err_sticky`=1.
6. **Gating and async reset.**
   - `ena`=0 with `valid`=1 and a garbage value -> no change to any output.
   - Assert `rst` mid-LOCKED, between clock edges -> `uo_out`=0x00 and `uio_out`=0x00 immediately; `uio_oe` stays 0xF0.

Source files
------------

// File: rtl/count_checker_pkg.sv
// Shared types and constants for the count-stream checker tile.
package count_checker_pkg;

  localparam int CNT_W = 8;
  localparam int RUN_W = 4;

  // Bit positions inside the uo_out status word.
  localparam int UO_ERR_LSB   = 0;
  localparam int UO_STICKY    = 4;
  localparam int UO_LOCKED    = 5;
  localparam int UO_STATE_LSB = 6;

  localparam logic [7:0] UIO_OE_VAL = 8'hF0;

  // Encoding 2'b11 is deliberately left unused; the core recovers it to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACQ    = 2'b01,
    ST_LOCKED = 2'b10
  } state_t;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [RUN_W-1:0] sat_inc(input logic [RUN_W-1:0] v);
    return (v == {RUN_W{1'b1}}) ? v : v + RUN_W'(1);
  endfunction

endpackage

// File: rtl/count_checker_if.sv
// Tile-pin bundle for the checker: stimulus side drives the inputs,
// the checker side drives the status outputs.
interface count_checker_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/count_checker_core.sv
// Lock/loss FSM plus error, sample and run counters for the count checker.
module count_checker_core
  import count_checker_pkg::*;
#(
  parameter int LOCK_N = 4,
  parameter int LOSS_N = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic [CNT_W-1:0] sample,
  input  logic             clear,
  output logic [RUN_W-1:0] err_cnt,
  output logic             err_sticky,
  output state_t           state,
  output logic [RUN_W-1:0] samp_cnt
);

  logic [CNT_W-1:0] expected;
  logic [RUN_W-1:0] good_run;
  logic [RUN_W-1:0] miss_run;

  logic             match;
  logic [RUN_W-1:0] good_inc;
  logic [RUN_W-1:0] miss_inc;
  logic [RUN_W-1:0] err_next;

  // Next-value helpers; a clear in the same cycle as an error restarts the count at one.
  always_comb begin
    match    = (sample == expected);
    good_inc = good_run + 4'd1;
    miss_inc = miss_run + 4'd1;
    err_next = clear ? 4'd1 : sat_inc(err_cnt);
  end

  // FSM and counters; clear only touches the error fields, never state or runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      expected   <= 8'd0;
      good_run   <= 4'd0;
      miss_run   <= 4'd0;
      err_cnt    <= 4'd0;
      err_sticky <= 1'b0;
      samp_cnt   <= 4'd0;
    end else begin
      if (clear) begin
        err_cnt    <= 4'd0;
        err_sticky <= 1'b0;
      end
      if (sample_en) begin
        // Always resync to what was observed, so one glitch costs one error.
        expected <= sample + 8'd1;
        samp_cnt <= samp_cnt + 4'd1;
        case (state)
          ST_IDLE: begin
            state    <= ST_ACQ;
            good_run <= 4'd0;
          end
          ST_ACQ: begin
            if (match) begin
              good_run <= good_inc;
              if (good_inc == RUN_W'(LOCK_N)) begin
                state    <= ST_LOCKED;
                miss_run <= 4'd0;
              end
            end else begin
              good_run <= 4'd0;
            end
          end
          ST_LOCKED: begin
            if (match) begin
              miss_run <= 4'd0;
            end else begin
              err_cnt    <= err_next;
              err_sticky <= 1'b1;
              miss_run   <= miss_inc;
              if (miss_inc == RUN_W'(LOSS_N)) begin
                state    <= ST_ACQ;
                good_run <= 4'd0;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end else if ((state != ST_IDLE) && (state != ST_ACQ) && (state != ST_LOCKED)) begin
        state <= ST_IDLE;
      end
    end
  end

endmodule

// File: rtl/tt_um_ethansam9_count_checker.sv
// Tiny Tapeout tile wrapper: pin mapping and sample gating around the checker core.
module tt_um_ethansam9_count_checker
  import count_checker_pkg::*;
#(
  parameter int LOCK_N = 4,
  parameter int LOSS_N = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic             sample_en;
  logic [RUN_W-1:0] err_cnt;
  logic             err_sticky;
  state_t           state;
  logic [RUN_W-1:0] samp_cnt;
  logic             unused_uio;

  assign sample_en  = ena & uio_in[0];
  assign unused_uio = &{1'b0, uio_in[7:2]};

  count_checker_core #(
    .LOCK_N(LOCK_N),
    .LOSS_N(LOSS_N)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample_en),
    .sample    (ui_in),
    .clear     (uio_in[1]),
    .err_cnt   (err_cnt),
    .err_sticky(err_sticky),
    .state     (state),
    .samp_cnt  (samp_cnt)
  );

  // Status word assembled purely from core registers.
  always_comb begin
    uo_out = 8'h00;
    uo_out[UO_ERR_LSB +: RUN_W] = err_cnt;
    uo_out[UO_STICKY]           = err_sticky;
    uo_out[UO_LOCKED]           = (state == ST_LOCKED);
    uo_out[UO_STATE_LSB +: 2]   = state;
    uio_out = {samp_cnt, 4'h0};
    uio_oe  = UIO_OE_VAL;
  end

endmodule

// File: tb/tb_tt_um_ethansam9_count_checker.sv
// Directed, table-driven bench for the count checker tile.
module tb_tt_um_ethansam9_count_checker;

  typedef struct {
    logic       ena;
    logic       valid;
    logic       clr;
    logic [7:0] samp;
    logic [7:0] exp_uo;
    logic [7:0] exp_uio;
  } vec_t;

  logic clk;
  logic rst;
  count_checker_if bus();

  int errors = 0;
  int checks = 0;
  logic [3:0] sc;
  vec_t vecs[$];

  tt_um_ethansam9_count_checker dut (
    .clk    (clk),
    .rst    (rst),
    .ena    (bus.ena),
    .ui_in  (bus.ui_in),
    .uio_in (bus.uio_in),
    .uo_out (bus.uo_out),
    .uio_out(bus.uio_out),
    .uio_oe (bus.uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp_v);
    checks = checks + 1;
    if (act !== exp_v) begin
      errors = errors + 1;
      $display("FAIL %s #%0d: got 0x%02h expected 0x%02h", name, idx, act, exp_v);
    end
  endtask

  // Append a vector; the expected sample count is tracked here by hand rule.
  function automatic void add(input logic e, input logic v, input logic c,
                              input logic [7:0] s, input logic [7:0] uo);
    vec_t t;
    if (e && v) sc = sc + 4'd1;
    t.ena = e; t.valid = v; t.clr = c; t.samp = s;
    t.exp_uo = uo; t.exp_uio = {sc, 4'h0};
    vecs.push_back(t);
  endfunction

  // Drive at a falling edge, let one rising edge happen, return at the next falling edge.
  task automatic step(input logic e, input logic v, input logic c, input logic [7:0] s);
    bus.ena    = e;
    bus.ui_in  = s;
    bus.uio_in = {6'b000000, c, v};
    @(negedge clk);
    if (e && v) sc = sc + 4'd1;
  endtask

  initial begin
    logic [7:0] e_nxt;
    logic [7:0] m1;
    logic [7:0] m2;
    logic [3:0] exp_err;
    logic [7:0] tmp;

    rst = 1'b1;
    bus.ena = 1'b0;
    bus.ui_in = 8'h00;
    bus.uio_in = 8'h00;

    // Build the directed table.
    sc = 4'd0;
    // Acquire and lock.
    add(1'b1, 1'b1, 1'b0, 8'd0, 8'h40);
    add(1'b1, 1'b1, 1'b0, 8'd1, 8'h40);
    add(1'b1, 1'b1, 1'b0, 8'd2, 8'h40);
    add(1'b1, 1'b1, 1'b0, 8'd3, 8'h40);
    add(1'b1, 1'b1, 1'b0, 8'd4, 8'hA0);
    // Jump to 253 (one error), clear while sampling, then wrap 255 -> 0 cleanly.
    add(1'b1, 1'b1, 1'b0, 8'd253, 8'hB1);
    add(1'b1, 1'b1, 1'b0, 8'd254, 8'hB1);
    add(1'b1, 1'b1, 1'b1, 8'd255, 8'hA0);
    add(1'b1, 1'b1, 1'b0, 8'd0,   8'hA0);
    add(1'b1, 1'b1, 1'b0, 8'd1,   8'hA0);
    for (int i = 2; i <= 10; i++) add(1'b1, 1'b1, 1'b0, 8'(i), 8'hA0);
    // Single glitch.
    add(1'b1, 1'b1, 1'b0, 8'd11, 8'hA0);
    add(1'b1, 1'b1, 1'b0, 8'd13, 8'hB1);
    add(1'b1, 1'b1, 1'b0, 8'd14, 8'hB1);
    // Clear with no sample, then loss of lock and relock.
    add(1'b1, 1'b0, 1'b1, 8'd99, 8'hA0);
    for (int i = 15; i <= 20; i++) add(1'b1, 1'b1, 1'b0, 8'(i), 8'hA0);
    add(1'b1, 1'b1, 1'b0, 8'd50, 8'hB1);
    add(1'b1, 1'b1, 1'b0, 8'd70, 8'h52);
    add(1'b1, 1'b1, 1'b0, 8'd71, 8'h52);
    add(1'b1, 1'b1, 1'b0, 8'd72, 8'h52);
    add(1'b1, 1'b1, 1'b0, 8'd73, 8'h52);
    add(1'b1, 1'b1, 1'b0, 8'd74, 8'hB2);
    // Gating: nothing moves, and the expected value is still 75 afterwards.
    add(1'b0, 1'b1, 1'b0, 8'd200, 8'hB2);
    add(1'b1, 1'b0, 1'b0, 8'd201, 8'hB2);
    add(1'b1, 1'b1, 1'b0, 8'd75,  8'hB2);

    // Reset state.
    @(negedge clk);
    check("reset uo_out",  0, bus.uo_out,  8'h00);
    check("reset uio_out", 0, bus.uio_out, 8'h00);
    check("reset uio_oe",  0, bus.uio_oe,  8'hF0);
    rst = 1'b0;

    sc = 4'd0;
    foreach (vecs[i]) begin
      step(vecs[i].ena, vecs[i].valid, vecs[i].clr, vecs[i].samp);
      check("vec uo_out",  i, bus.uo_out,  vecs[i].exp_uo);
      check("vec uio_out", i, bus.uio_out, vecs[i].exp_uio);
      check("vec uio_oe",  i, bus.uio_oe,  8'hF0);
    end

    // Saturation: clear, then ten lock/loss rounds of two errors each.
    e_nxt = 8'd76;
    step(1'b1, 1'b0, 1'b1, 8'd0);
    check("sat pre-clear", 0, bus.uo_out, 8'hA0);
    for (int k = 1; k <= 10; k++) begin
      m1 = e_nxt + 8'd7;
      step(1'b1, 1'b1, 1'b0, m1);
      m2 = m1 + 8'd7;
      step(1'b1, 1'b1, 1'b0, m2);
      for (int j = 1; j <= 4; j++) begin
        tmp = m2 + 8'(j);
        step(1'b1, 1'b1, 1'b0, tmp);
      end
      e_nxt = m2 + 8'd5;
      exp_err = (2 * k > 15) ? 4'd15 : 4'(2 * k);
      check("sat round", k, bus.uo_out, {2'b10, 1'b1, 1'b1, exp_err});
    end
    check("sat samp_cnt", 0, bus.uio_out, {sc, 4'h0});
    step(1'b1, 1'b0, 1'b1, 8'd0);
    check("clear alone", 0, bus.uo_out, 8'hA0);
    tmp = e_nxt + 8'd7;
    step(1'b1, 1'b1, 1'b1, tmp);
    check("clear+miss", 0, bus.uo_out, 8'hB1);

    // Asynchronous reset between clock edges while LOCKED.
    #2;
    rst = 1'b1;
    #1;
    check("async rst uo_out",  0, bus.uo_out,  8'h00);
    check("async rst uio_out", 0, bus.uio_out, 8'h00);
    check("async rst uio_oe",  0, bus.uio_oe,  8'hF0);
    @(negedge clk);
    rst = 1'b0;
    sc = 4'd0;
    step(1'b1, 1'b1, 1'b0, 8'd100);
    check("post-rst acq uo",  0, bus.uo_out,  8'h40);
    check("post-rst acq uio", 0, bus.uio_out, 8'h10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
